per2axi_req_channel: RTL and testbench
======================================

Name: per2axi_req_channel

Overview:
Request half of the peripheral-to-AXI bridge. It accepts single 32-bit peripheral-bus requests (load, store, RISC-V AMO) from the cluster peripheral interconnect and issues them as single-beat AXI4+ATOP master transactions (AR, or AW+W). It notifies the companion response channel of each issued transaction and blocks until that channel reports completion. Only one transaction is outstanding at a time.

Parameters:
PER_ADDR_WIDTH, 32, peripheral address width
PER_ID_WIDTH, 5, peripheral request ID width
AXI_ADDR_WIDTH, 32, AXI address width (>= PER_ADDR_WIDTH)
AXI_DATA_WIDTH, 64, AXI data width (fixed 64; other values are illegal)
AXI_USER_WIDTH, 6, AXI user width
AXI_ID_WIDTH, 5, AXI ID width (>= PER_ID_WIDTH)
AXI_STRB_WIDTH, AXI_DATA_WIDTH/8, derived; do not override

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
cluster_id_i  in  6  cluster index for address globalisation
per_slave_req_i / per_slave_add_i / per_slave_we_i / per_slave_atop_i / per_slave_wdata_i / per_slave_be_i / per_slave_id_i  in  1/PER_ADDR_WIDTH/1/6/32/4/PER_ID_WIDTH  peripheral request; we is active low
per_slave_gnt_o  out  1  request accepted
axi_master_aw_{valid_o,addr_o,prot_o,region_o,len_o,size_o,burst_o,lock_o,atop_o,cache_o,qos_o,id_o,user_o}  out  1/AXI_ADDR_WIDTH/3/4/8/3/2/1/6/4/4/AXI_ID_WIDTH/AXI_USER_WIDTH  AW channel
axi_master_aw_ready_i  in  1
axi_master_ar_{valid_o..user_o}  out  as AW minus atop  AR channel
axi_master_ar_ready_i  in  1
axi_master_w_{valid_o,data_o,strb_o,user_o,last_o}  out  1/64/8/AXI_USER_WIDTH/1  W channel
axi_master_w_ready_i  in  1
trans_req_o / trans_we_o / trans_atop_r_o / trans_id_o  out  1/1/1/PER_ID_WIDTH  issue notification to response channel
trans_r_valid_i  in  1  response channel signals completion
busy_o  out  1  transaction in flight

Behaviour:
- Reset: state Idle, all valid/gnt/trans_req/busy outputs 0, request register cleared. Reset mid-transaction abandons it; no AXI valid is held high across reset.
- States: Idle, Issue, WaitResp.
- Idle: gnt_o = req_i (combinational, same cycle). On req&gnt, register add/we/atop/wdata/be/id, pulse trans_req_o for one cycle with trans_we_o=we_i, trans_id_o=id_i, trans_atop_r_o per mapping; go to Issue. busy_o=0.
- Issue (busy_o=1, gnt_o=0): read (we=1): ar_valid_o=1 until ar_ready_i. Write (we=0): aw_valid_o and w_valid_o asserted together; each deasserts independently after its own handshake (per-channel done flags); W may complete before, with, or after AW. Leaves for WaitResp when all required handshakes are done.
- WaitResp (busy_o=1): return to Idle on trans_r_valid_i; next request can be granted the following cycle. trans_r_valid_i asserting during Issue is recorded; exit follows the last handshake directly to Idle.
- Address: axi addr = zero-extended per address + 32'h0040_0000*cluster_id_i, modulo 2^AXI_ADDR_WIDTH.
- Fixed attributes: len 0, size 3'b010, burst INCR, last 1, lock/cache/qos/region/prot/user 0, id = per ID zero-extended.
- W data: 32-bit word replicated to both halves; strb[7:4]=be if addr[2], else strb[3:0]=be; other nibble 0.
- AMO mapping (atop_i nonzero, we=0): AMO_SWAP -> ATOMICSWAP (6'b110000); ADD/XOR/OR/MAX/MIN/MAXU/MINU -> ATOMICLOAD with ADD/EOR/SET/SMAX/SMIN/UMAX/UMIN, little endian; AMO_AND -> ATOMICLOAD CLR with wdata inverted. trans_atop_r_o=1 for all atomics (response carries R data). LR/SC/unknown codes: simulation assertion error; issued as plain write.

Decomposition:
- Reuse axi_pkg (ATOP_* constants) and riscv_defines (AMO_*); add an amo->atop function and the cluster address stride constant to a shared per2axi_pkg.
- Sub-module: per2axi_amo_map (combinational atop translation plus data-invert flag), reused by tests.

Test Plan:
- Read 0x1000_0004, cluster 2, id 3, ar_ready delayed 3 cycles -> ar_addr 0x1080_0004, ar_valid held 3 cycles, trans_req pulse id 3 we 1, busy until trans_r_valid.
- Write 0x0000_0008 data 0xDEADBEEF be 4'b0011 -> strb 8'h03, data 0xDEADBEEF_DEADBEEF; addr[2]=1 variant -> strb 8'h30.
- W ready before AW ready (2 cycles apart) -> w_valid drops after its handshake, aw_valid persists, single transaction.
- AMO_AND wdata 0x0000_00FF -> atop 6'b100001 (CLR), W data low word 0xFFFF_FF00, trans_atop_r_o 1.
- Back-to-back requests -> second gnt only in cycle after trans_r_valid; never two outstanding.
- Reset asserted during Issue -> all valids 0 immediately, Idle, next request handled normally.

Source files
------------

// File: rtl/per2axi_req_channel_pkg.sv
// Shared definitions for the peripheral-to-AXI request channel.
//   - cluster address stride used to globalise peripheral addresses
//   - AXI5 ATOP encodings and RISC-V AMO function codes
//   - request-channel FSM state type
//   - amo_to_atop(): translates a peripheral AMO request into an AXI ATOP
package per2axi_req_channel_pkg;

  // Each cluster owns a 4 MiB window of the global address map.
  localparam logic [31:0] CLUSTER_ADDR_STRIDE = 32'h0040_0000;

  // AXI ATOP fields: atop[5:4] = type, atop[3] = endianness, atop[2:0] = op.
  localparam logic [5:0] ATOP_NONE        = 6'b000000;
  localparam logic [5:0] ATOP_ATOMICSWAP  = 6'b110000;
  localparam logic [1:0] ATOP_ATOMICLOAD  = 2'b10;
  localparam logic       ATOP_LITTLE_END  = 1'b0;
  localparam logic [2:0] ATOP_ADD         = 3'b000;
  localparam logic [2:0] ATOP_CLR         = 3'b001;
  localparam logic [2:0] ATOP_EOR         = 3'b010;
  localparam logic [2:0] ATOP_SET         = 3'b011;
  localparam logic [2:0] ATOP_SMAX        = 3'b100;
  localparam logic [2:0] ATOP_SMIN        = 3'b101;
  localparam logic [2:0] ATOP_UMAX        = 3'b110;
  localparam logic [2:0] ATOP_UMIN        = 3'b111;

  // RISC-V AMO function codes (funct5). The peripheral atop field carries
  // an "atomic" flag in bit 5 and the funct5 code in bits 4:0.
  localparam logic [4:0] AMO_ADD  = 5'b00000;
  localparam logic [4:0] AMO_SWAP = 5'b00001;
  localparam logic [4:0] AMO_LR   = 5'b00010;
  localparam logic [4:0] AMO_SC   = 5'b00011;
  localparam logic [4:0] AMO_XOR  = 5'b00100;
  localparam logic [4:0] AMO_OR   = 5'b01000;
  localparam logic [4:0] AMO_AND  = 5'b01100;
  localparam logic [4:0] AMO_MIN  = 5'b10000;
  localparam logic [4:0] AMO_MAX  = 5'b10100;
  localparam logic [4:0] AMO_MINU = 5'b11000;
  localparam logic [4:0] AMO_MAXU = 5'b11100;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [5:0] atop;       // AXI ATOP to issue on AW
    logic       inv_wdata;  // write data must be inverted (AND -> CLR)
    logic       atop_r;     // response carries R data
    logic       illegal;    // code cannot be mapped; issued as plain write
  } amo_xlat_t;

  function automatic amo_xlat_t amo_to_atop(input logic [5:0] per_atop,
                                            input logic       per_we);
    amo_xlat_t x;
    x = '0;
    // Reads (we=1) and plain writes (atop=0) carry no atomic.
    if (!per_we && (per_atop != 6'b0)) begin
      if (per_atop[5]) begin
        case (per_atop[4:0])
          AMO_SWAP: x.atop = ATOP_ATOMICSWAP;
          AMO_ADD:  x.atop = {ATOP_ATOMICLOAD, ATOP_LITTLE_END, ATOP_ADD};
          AMO_XOR:  x.atop = {ATOP_ATOMICLOAD, ATOP_LITTLE_END, ATOP_EOR};
          AMO_OR:   x.atop = {ATOP_ATOMICLOAD, ATOP_LITTLE_END, ATOP_SET};
          AMO_MAX:  x.atop = {ATOP_ATOMICLOAD, ATOP_LITTLE_END, ATOP_SMAX};
          AMO_MIN:  x.atop = {ATOP_ATOMICLOAD, ATOP_LITTLE_END, ATOP_SMIN};
          AMO_MAXU: x.atop = {ATOP_ATOMICLOAD, ATOP_LITTLE_END, ATOP_UMAX};
          AMO_MINU: x.atop = {ATOP_ATOMICLOAD, ATOP_LITTLE_END, ATOP_UMIN};
          // AXI has no atomic AND; AND with w equals CLR with ~w.
          AMO_AND: begin
            x.atop      = {ATOP_ATOMICLOAD, ATOP_LITTLE_END, ATOP_CLR};
            x.inv_wdata = 1'b1;
          end
          default:  x.illegal = 1'b1;  // LR, SC and unassigned codes
        endcase
      end else begin
        x.illegal = 1'b1;
      end
      x.atop_r = ~x.illegal;
    end
    return x;
  endfunction

endpackage

// File: rtl/per2axi_req_channel_if.sv
// Bundle of the peripheral request port, the AXI AW/AR/W master channels
// and the handshake towards the companion response channel.
//   master : view of the request channel (drives AXI valids, gnt, trans_*)
//   slave  : view of the surroundings (peripheral master, AXI slave,
//            response channel)
interface per2axi_req_channel_if #(
  parameter int unsigned PER_ADDR_WIDTH = 32,
  parameter int unsigned PER_ID_WIDTH   = 5,
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_USER_WIDTH = 6,
  parameter int unsigned AXI_ID_WIDTH   = 5
);
  localparam int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

  // peripheral slave port (we is active low: 1 = read)
  logic                      per_req;
  logic [PER_ADDR_WIDTH-1:0] per_add;
  logic                      per_we;
  logic [5:0]                per_atop;
  logic [31:0]               per_wdata;
  logic [3:0]                per_be;
  logic [PER_ID_WIDTH-1:0]   per_id;
  logic                      per_gnt;

  // AW channel
  logic                      aw_valid;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr;
  logic [2:0]                aw_prot;
  logic [3:0]                aw_region;
  logic [7:0]                aw_len;
  logic [2:0]                aw_size;
  logic [1:0]                aw_burst;
  logic                      aw_lock;
  logic [5:0]                aw_atop;
  logic [3:0]                aw_cache;
  logic [3:0]                aw_qos;
  logic [AXI_ID_WIDTH-1:0]   aw_id;
  logic [AXI_USER_WIDTH-1:0] aw_user;
  logic                      aw_ready;

  // AR channel
  logic                      ar_valid;
  logic [AXI_ADDR_WIDTH-1:0] ar_addr;
  logic [2:0]                ar_prot;
  logic [3:0]                ar_region;
  logic [7:0]                ar_len;
  logic [2:0]                ar_size;
  logic [1:0]                ar_burst;
  logic                      ar_lock;
  logic [3:0]                ar_cache;
  logic [3:0]                ar_qos;
  logic [AXI_ID_WIDTH-1:0]   ar_id;
  logic [AXI_USER_WIDTH-1:0] ar_user;
  logic                      ar_ready;

  // W channel
  logic                      w_valid;
  logic [AXI_DATA_WIDTH-1:0] w_data;
  logic [AXI_STRB_WIDTH-1:0] w_strb;
  logic [AXI_USER_WIDTH-1:0] w_user;
  logic                      w_last;
  logic                      w_ready;

  // response-channel coupling
  logic                      trans_req;
  logic                      trans_we;
  logic                      trans_atop_r;
  logic [PER_ID_WIDTH-1:0]   trans_id;
  logic                      trans_r_valid;
  logic                      busy;

  modport master (
    input  per_req, per_add, per_we, per_atop, per_wdata, per_be, per_id,
    output per_gnt,
    output aw_valid, aw_addr, aw_prot, aw_region, aw_len, aw_size, aw_burst,
           aw_lock, aw_atop, aw_cache, aw_qos, aw_id, aw_user,
    input  aw_ready,
    output ar_valid, ar_addr, ar_prot, ar_region, ar_len, ar_size, ar_burst,
           ar_lock, ar_cache, ar_qos, ar_id, ar_user,
    input  ar_ready,
    output w_valid, w_data, w_strb, w_user, w_last,
    input  w_ready,
    output trans_req, trans_we, trans_atop_r, trans_id,
    input  trans_r_valid,
    output busy
  );

  modport slave (
    output per_req, per_add, per_we, per_atop, per_wdata, per_be, per_id,
    input  per_gnt,
    input  aw_valid, aw_addr, aw_prot, aw_region, aw_len, aw_size, aw_burst,
           aw_lock, aw_atop, aw_cache, aw_qos, aw_id, aw_user,
    output aw_ready,
    input  ar_valid, ar_addr, ar_prot, ar_region, ar_len, ar_size, ar_burst,
           ar_lock, ar_cache, ar_qos, ar_id, ar_user,
    output ar_ready,
    input  w_valid, w_data, w_strb, w_user, w_last,
    output w_ready,
    input  trans_req, trans_we, trans_atop_r, trans_id,
    output trans_r_valid,
    input  busy
  );

endinterface

// File: rtl/per2axi_amo_map.sv
// Combinational translation of a peripheral atomic request into AXI ATOP.
//   per_atop_i  : peripheral atop field ({atomic flag, funct5})
//   per_we_i    : peripheral write-enable (active low)
//   axi_atop_o  : ATOP for the AW channel (0 for non-atomic requests)
//   inv_wdata_o : write data has to be bit-inverted before issue
//   atop_r_o    : transaction returns R data
//   illegal_o   : atomic code without AXI equivalent
module per2axi_amo_map
  import per2axi_req_channel_pkg::*;
(
  input  logic [5:0] per_atop_i,
  input  logic       per_we_i,
  output logic [5:0] axi_atop_o,
  output logic       inv_wdata_o,
  output logic       atop_r_o,
  output logic       illegal_o
);

  amo_xlat_t xlat;

  always_comb begin
    xlat = amo_to_atop(per_atop_i, per_we_i);
  end

  assign axi_atop_o  = xlat.atop;
  assign inv_wdata_o = xlat.inv_wdata;
  assign atop_r_o    = xlat.atop_r;
  assign illegal_o   = xlat.illegal;

endmodule

// File: rtl/per2axi_req_channel.sv
// Request half of the peripheral-to-AXI bridge. A granted peripheral request
// is captured and issued as a single-beat AXI transaction (AR, or AW+W),
// the response channel is notified, and no new request is granted until the
// response channel reports completion (one transaction outstanding).
//   clk_i        : clock
//   rst_i        : asynchronous active-high reset
//   cluster_id_i : cluster index used to globalise the peripheral address
//   bus          : peripheral port, AXI AW/AR/W master, response coupling
module per2axi_req_channel
  import per2axi_req_channel_pkg::*;
#(
  parameter int unsigned PER_ADDR_WIDTH = 32,
  parameter int unsigned PER_ID_WIDTH   = 5,
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_USER_WIDTH = 6,
  parameter int unsigned AXI_ID_WIDTH   = 5
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [5:0]             cluster_id_i,
  per2axi_req_channel_if.master  bus
);

  localparam int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

  state_e state_q, state_d;

  // captured request
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                      we_q, we_d;
  logic [5:0]                atop_q, atop_d;
  logic [31:0]               wdata_q, wdata_d;
  logic [3:0]                be_q, be_d;
  logic [PER_ID_WIDTH-1:0]   id_q, id_d;

  // per-channel completion tracking while issuing
  logic aw_done_q, aw_done_d;
  logic w_done_q, w_done_d;
  logic resp_seen_q, resp_seen_d;

  logic                      accept;
  logic [AXI_ADDR_WIDTH-1:0] glob_addr;
  logic [5:0]                map_atop;
  logic                      map_inv, map_atop_r, map_illegal;
  logic                      gnt, busy, ar_valid, aw_valid, w_valid;
  logic                      ar_hs, aw_hs, w_hs, issue_done;

  per2axi_amo_map u_amo_map (
    .per_atop_i  (bus.per_atop),
    .per_we_i    (bus.per_we),
    .axi_atop_o  (map_atop),
    .inv_wdata_o (map_inv),
    .atop_r_o    (map_atop_r),
    .illegal_o   (map_illegal)
  );

  // Globalised address; the sum wraps at AXI_ADDR_WIDTH bits.
  assign glob_addr = AXI_ADDR_WIDTH'(bus.per_add)
                   + AXI_ADDR_WIDTH'(CLUSTER_ADDR_STRIDE) * AXI_ADDR_WIDTH'(cluster_id_i);

  assign accept = bus.per_req & (state_q == ST_IDLE);

  assign ar_hs = ar_valid & bus.ar_ready;
  assign aw_hs = aw_valid & bus.aw_ready;
  assign w_hs  = w_valid & bus.w_ready;

  // A channel counts as done if it finished earlier or finishes this cycle.
  assign issue_done = we_q ? ar_hs
                           : ((aw_done_q | aw_hs) & (w_done_q | w_hs));

  // ---------------- state register ----------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      atop_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      id_q        <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      resp_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      atop_q      <= atop_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      id_q        <= id_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      resp_seen_q <= resp_seen_d;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        // A completion reported while still issuing skips WaitResp.
        if (issue_done) begin
          state_d = (resp_seen_q | bus.trans_r_valid) ? ST_IDLE : ST_WAIT_RESP;
        end
      end
      ST_WAIT_RESP: begin
        if (bus.trans_r_valid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request capture; AND is stored with inverted data for the CLR atomic.
  always_comb begin
    addr_d  = addr_q;
    we_d    = we_q;
    atop_d  = atop_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    id_d    = id_q;
    if (accept) begin
      addr_d  = glob_addr;
      we_d    = bus.per_we;
      atop_d  = map_atop;
      wdata_d = map_inv ? ~bus.per_wdata : bus.per_wdata;
      be_d    = bus.per_be;
      id_d    = bus.per_id;
    end
  end

  // Done flags start cleared in Idle and accumulate during Issue.
  always_comb begin
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    resp_seen_d = resp_seen_q;
    case (state_q)
      ST_IDLE: begin
        aw_done_d   = 1'b0;
        w_done_d    = 1'b0;
        resp_seen_d = 1'b0;
      end
      ST_ISSUE: begin
        aw_done_d   = aw_done_q | aw_hs;
        w_done_d    = w_done_q | w_hs;
        resp_seen_d = resp_seen_q | bus.trans_r_valid;
      end
      default: ;
    endcase
  end

  // ---------------- output logic ----------------
  always_comb begin
    gnt      = 1'b0;
    busy     = 1'b0;
    ar_valid = 1'b0;
    aw_valid = 1'b0;
    w_valid  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        gnt = bus.per_req;
      end
      ST_ISSUE: begin
        busy     = 1'b1;
        ar_valid = we_q;
        aw_valid = ~we_q & ~aw_done_q;
        w_valid  = ~we_q & ~w_done_q;
      end
      ST_WAIT_RESP: begin
        busy = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.per_gnt = gnt;
  assign bus.busy    = busy;

  // Issue notification is combinational in the accepting cycle.
  assign bus.trans_req    = accept;
  assign bus.trans_we     = bus.per_we;
  assign bus.trans_id     = bus.per_id;
  assign bus.trans_atop_r = map_atop_r;

  assign bus.aw_valid  = aw_valid;
  assign bus.aw_addr   = addr_q;
  assign bus.aw_prot   = 3'b000;
  assign bus.aw_region = 4'h0;
  assign bus.aw_len    = 8'h00;
  assign bus.aw_size   = 3'b010;
  assign bus.aw_burst  = 2'b01;
  assign bus.aw_lock   = 1'b0;
  assign bus.aw_atop   = atop_q;
  assign bus.aw_cache  = 4'h0;
  assign bus.aw_qos    = 4'h0;
  assign bus.aw_id     = AXI_ID_WIDTH'(id_q);
  assign bus.aw_user   = '0;

  assign bus.ar_valid  = ar_valid;
  assign bus.ar_addr   = addr_q;
  assign bus.ar_prot   = 3'b000;
  assign bus.ar_region = 4'h0;
  assign bus.ar_len    = 8'h00;
  assign bus.ar_size   = 3'b010;
  assign bus.ar_burst  = 2'b01;
  assign bus.ar_lock   = 1'b0;
  assign bus.ar_cache  = 4'h0;
  assign bus.ar_qos    = 4'h0;
  assign bus.ar_id     = AXI_ID_WIDTH'(id_q);
  assign bus.ar_user   = '0;

  // 32-bit word on both halves of the 64-bit bus; address bit 2 picks lanes.
  assign bus.w_valid = w_valid;
  assign bus.w_data  = AXI_DATA_WIDTH'({wdata_q, wdata_q});
  assign bus.w_strb  = AXI_STRB_WIDTH'(addr_q[2] ? {be_q, 4'h0} : {4'h0, be_q});
  assign bus.w_user  = '0;
  assign bus.w_last  = 1'b1;

  always_ff @(posedge clk_i) begin
    if (!rst_i && accept) begin
      assert (!map_illegal)
        else $error("per2axi_req_channel: unsupported atomic code %b issued as plain write",
                    bus.per_atop);
    end
  end

endmodule

// File: tb/tb_per2axi_req_channel.sv
module tb_per2axi_req_channel;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] cluster_id;

  always #5 clk = ~clk;

  per2axi_req_channel_if #(
    .PER_ADDR_WIDTH(32), .PER_ID_WIDTH(5), .AXI_ADDR_WIDTH(32),
    .AXI_DATA_WIDTH(64), .AXI_USER_WIDTH(6), .AXI_ID_WIDTH(5)
  ) bus ();

  per2axi_req_channel #(
    .PER_ADDR_WIDTH(32), .PER_ID_WIDTH(5), .AXI_ADDR_WIDTH(32),
    .AXI_DATA_WIDTH(64), .AXI_USER_WIDTH(6), .AXI_ID_WIDTH(5)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .cluster_id_i (cluster_id),
    .bus          (bus)
  );

  int checks   = 0;
  int failures = 0;

  // RISC-V funct5 codes and their expected AXI ATOP encodings
  logic [4:0] amo_tab  [9];
  logic [5:0] atop_tab [9];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [5:0] ref_atop(input logic [5:0] a);
    logic [5:0] r;
    r = 6'b0;
    for (int i = 0; i < 9; i++) if (a[5] && a[4:0] == amo_tab[i]) r = atop_tab[i];
    return r;
  endfunction

  task automatic drive_quiet();
    bus.per_req = 1'b0; bus.per_add = '0; bus.per_we = 1'b1; bus.per_atop = '0;
    bus.per_wdata = '0; bus.per_be = '0; bus.per_id = '0;
    bus.aw_ready = 1'b0; bus.ar_ready = 1'b0; bus.w_ready = 1'b0;
    bus.trans_r_valid = 1'b0;
  endtask

  // One transaction: accept cycle, then Issue/WaitResp cycles. Delays are
  // counted in cycles from the first cycle after the grant; each ready /
  // completion is presented for exactly one cycle at its delay.
  task automatic do_txn(input logic [31:0] addr, input logic we, input logic [5:0] atop,
                        input logic [31:0] wdata, input logic [3:0] be, input logic [4:0] id,
                        input logic [5:0] cl, input int ar_dly, input int aw_dly,
                        input int w_dly, input int resp_dly, input bit hold_req);
    logic [31:0] exp_addr, wd;
    logic [5:0]  exp_atop;
    logic [7:0]  exp_strb;
    int          hs_end, last;
    exp_addr = addr + 32'h0040_0000 * {26'b0, cl};
    exp_atop = we ? 6'b0 : ref_atop(atop);
    wd       = (!we && atop == 6'b101100) ? ~wdata : wdata;
    exp_strb = addr[2] ? {be, 4'h0} : {4'h0, be};
    hs_end   = we ? ar_dly : imax(aw_dly, w_dly);
    last     = imax(hs_end, resp_dly);

    @(posedge clk); #1;
    cluster_id = cl;
    bus.per_req = 1'b1; bus.per_add = addr; bus.per_we = we; bus.per_atop = atop;
    bus.per_wdata = wdata; bus.per_be = be; bus.per_id = id;
    bus.ar_ready = 1'b0; bus.aw_ready = 1'b0; bus.w_ready = 1'b0; bus.trans_r_valid = 1'b0;
    #1;
    check_eq("idle_busy", bus.busy, 1'b0);
    check_eq("gnt", bus.per_gnt, 1'b1);
    check_eq("trans_req", bus.trans_req, 1'b1);
    check_eq("trans_we", bus.trans_we, we);
    check_eq("trans_id", bus.trans_id, id);
    check_eq("trans_atop_r", bus.trans_atop_r, exp_atop != 6'b0);
    check_eq("idle_valids", {bus.ar_valid, bus.aw_valid, bus.w_valid}, 3'b000);

    for (int k = 0; k <= last; k++) begin
      @(posedge clk); #1;
      bus.per_req       = hold_req;
      bus.ar_ready      = (k == ar_dly);
      bus.aw_ready      = (k == aw_dly);
      bus.w_ready       = (k == w_dly);
      bus.trans_r_valid = (k == resp_dly);
      #1;
      check_eq("busy", bus.busy, 1'b1);
      check_eq("gnt_blocked", bus.per_gnt, 1'b0);
      check_eq("trans_req_once", bus.trans_req, 1'b0);
      check_eq("ar_valid", bus.ar_valid, we && (k <= ar_dly));
      check_eq("aw_valid", bus.aw_valid, !we && (k <= aw_dly));
      check_eq("w_valid", bus.w_valid, !we && (k <= w_dly));
      if (k == 0) begin
        if (we) begin
          check_eq("ar_addr", bus.ar_addr, exp_addr);
          check_eq("ar_id", bus.ar_id, id);
          check_eq("ar_len_size_burst", {bus.ar_len, bus.ar_size, bus.ar_burst}, {8'h00, 3'b010, 2'b01});
        end else begin
          check_eq("aw_addr", bus.aw_addr, exp_addr);
          check_eq("aw_atop", bus.aw_atop, exp_atop);
          check_eq("aw_id", bus.aw_id, id);
          check_eq("aw_len_size_burst", {bus.aw_len, bus.aw_size, bus.aw_burst}, {8'h00, 3'b010, 2'b01});
          check_eq("w_data", bus.w_data, {wd, wd});
          check_eq("w_strb", bus.w_strb, exp_strb);
          check_eq("w_last", bus.w_last, 1'b1);
        end
      end
    end
  endtask

  initial begin
    logic [5:0]  a;
    logic        we;
    amo_tab[0] = 5'b00001; atop_tab[0] = 6'b110000; // SWAP -> ATOMICSWAP
    amo_tab[1] = 5'b00000; atop_tab[1] = 6'b100000; // ADD
    amo_tab[2] = 5'b00100; atop_tab[2] = 6'b100010; // XOR -> EOR
    amo_tab[3] = 5'b01100; atop_tab[3] = 6'b100001; // AND -> CLR
    amo_tab[4] = 5'b01000; atop_tab[4] = 6'b100011; // OR  -> SET
    amo_tab[5] = 5'b10100; atop_tab[5] = 6'b100100; // MAX -> SMAX
    amo_tab[6] = 5'b10000; atop_tab[6] = 6'b100101; // MIN -> SMIN
    amo_tab[7] = 5'b11100; atop_tab[7] = 6'b100110; // MAXU -> UMAX
    amo_tab[8] = 5'b11000; atop_tab[8] = 6'b100111; // MINU -> UMIN

    rst = 1'b1;
    cluster_id = 6'd0;
    drive_quiet();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", bus.busy, 1'b0);
    check_eq("rst_gnt", bus.per_gnt, 1'b0);
    check_eq("rst_trans_req", bus.trans_req, 1'b0);
    check_eq("rst_valids", {bus.ar_valid, bus.aw_valid, bus.w_valid}, 3'b000);
    check_eq("rst_addr_cleared", bus.ar_addr, 32'h0);
    check_eq("rst_strb_cleared", bus.w_strb, 8'h00);
    rst = 1'b0;

    // directed cases
    do_txn(32'h1000_0004, 1'b1, 6'b0, 32'h0, 4'hF, 5'd3, 6'd2, 3, 0, 0, 6, 1'b0);
    do_txn(32'h0000_0008, 1'b0, 6'b0, 32'hDEAD_BEEF, 4'b0011, 5'd1, 6'd0, 0, 0, 0, 2, 1'b0);
    do_txn(32'h0000_000C, 1'b0, 6'b0, 32'hDEAD_BEEF, 4'b0011, 5'd2, 6'd0, 0, 1, 0, 1, 1'b0);
    do_txn(32'h0000_0100, 1'b0, 6'b0, 32'h1234_5678, 4'hF, 5'd4, 6'd1, 0, 3, 1, 5, 1'b0);
    do_txn(32'h0000_0200, 1'b0, 6'b101100, 32'h0000_00FF, 4'hF, 5'd5, 6'd0, 0, 1, 1, 3, 1'b0);
    // completion reported while still issuing, then back-to-back with req held
    do_txn(32'h0000_0300, 1'b0, 6'b100001, 32'hCAFE_F00D, 4'hF, 5'd6, 6'd3, 0, 2, 2, 0, 1'b1);
    do_txn(32'h0000_0304, 1'b1, 6'b0, 32'h0, 4'hF, 5'd7, 6'd3, 0, 0, 0, 1, 1'b1);
    do_txn(32'hFFFF_FFF0, 1'b1, 6'b0, 32'h0, 4'hF, 5'd8, 6'd63, 1, 0, 0, 4, 1'b1);

    // reset while issuing a write whose channels never become ready
    @(posedge clk); #1;
    cluster_id = 6'd0;
    bus.per_req = 1'b1; bus.per_add = 32'h40; bus.per_we = 1'b0; bus.per_atop = 6'b0;
    bus.per_wdata = 32'h5555_AAAA; bus.per_be = 4'hF; bus.per_id = 5'd9;
    bus.aw_ready = 1'b0; bus.w_ready = 1'b0; bus.ar_ready = 1'b0; bus.trans_r_valid = 1'b0;
    #1;
    check_eq("rstmid_gnt", bus.per_gnt, 1'b1);
    @(posedge clk); #1;
    bus.per_req = 1'b0;
    #1;
    check_eq("rstmid_pre_valids", {bus.aw_valid, bus.w_valid}, 2'b11);
    #2;
    rst = 1'b1;
    #1;
    check_eq("rstmid_valids", {bus.ar_valid, bus.aw_valid, bus.w_valid}, 3'b000);
    check_eq("rstmid_busy", bus.busy, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    do_txn(32'h0000_0044, 1'b0, 6'b0, 32'h0BAD_F00D, 4'b1100, 5'd10, 6'd1, 0, 0, 2, 3, 1'b0);

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      we = 1'($urandom_range(0, 1));
      a  = 6'b0;
      if (!we && ($urandom_range(0, 9) < 4)) a = {1'b1, amo_tab[$urandom_range(0, 8)]};
      do_txn($urandom(), we, a, $urandom(), 4'($urandom_range(1, 15)),
             5'($urandom_range(0, 31)), 6'($urandom_range(0, 63)),
             $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
             $urandom_range(0, 8), 1'($urandom_range(0, 1)));
    end

    @(posedge clk); #1;
    drive_quiet();
    #1;
    check_eq("end_busy", bus.busy, 1'b0);
    check_eq("end_valids", {bus.ar_valid, bus.aw_valid, bus.w_valid}, 3'b000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
